// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers and default sizing.
// Holds bin2gray/gray2bin and the defaults used by both pointer domains.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 5;
  localparam int FIFO_AFULL_THRESH = (1 << FIFO_ADDRSIZE) - 4;

  // Pointers up to 32 bits wide.
  // Callers zero-extend and then slice the result.
  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side pointer bus between the FIFO write logic and its surroundings.
// master: the pointer/full block; slave: the write-side user and RAM.
// wlevel exists only when FIFO_WLEVEL_EN is defined.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) ();

  logic                clear;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic                wovf;
`ifdef FIFO_WLEVEL_EN
  logic [ADDRSIZE:0]   wlevel;
`endif

  modport master (
    input  clear,
    input  winc,
    input  wq2_rptr,
    output waddr,
    output wptr,
    output wfull,
    output walmost_full,
`ifdef FIFO_WLEVEL_EN
    output wlevel,
`endif
    output wovf
  );

  modport slave (
    output clear,
    output winc,
    output wq2_rptr,
    input  waddr,
    input  wptr,
    input  wfull,
    input  walmost_full,
`ifdef FIFO_WLEVEL_EN
    input  wlevel,
`endif
    input  wovf
  );

endinterface

// File: rtl/fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary decoder (XOR prefix from the MSB down).
// Ports: gray (W bits in), bin (W bits out).
module gray2bin #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // bin[i] is the XOR of all Gray bits at or above i.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write pointer, full / almost-full and sticky overflow logic.
// Ports: clk, rst (async active-low), w (fifo_wptr_full_if.master):
//   clear, winc, wq2_rptr in; waddr, wptr, wfull, walmost_full, wovf out.
// Macro FIFO_WLEVEL_EN adds the registered wlevel occupancy output.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wptr_full_if.master   w
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AF = PW'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin_q;
  logic [ADDRSIZE:0] wptr_q;
  logic              wfull_q;
  logic              wafull_q;
  logic              wovf_q;

  logic [ADDRSIZE:0] wbin_d;
  logic [ADDRSIZE:0] wptr_d;
  logic              wfull_d;
  logic              wafull_d;
  logic              wovf_d;

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbin_nx;
  logic [ADDRSIZE:0] wgray_nx;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] diff;
  logic              wr_en;
  ptr_word_t         g32;

`ifdef FIFO_WLEVEL_EN
  logic [ADDRSIZE:0] wlevel_q;
  logic [ADDRSIZE:0] wlevel_d;
`endif

  gray2bin #(
    .W (PW)
  ) u_g2b (
    .gray (w.wq2_rptr),
    .bin  (rbin)
  );

  // A flush takes priority over a write in the same cycle.
  assign wr_en = w.winc & ~wfull_q & ~w.clear;

  always_comb begin
    wbin_nx  = wbin_q + {{ADDRSIZE{1'b0}}, wr_en};
    g32      = bin2gray(ptr_word_t'(wbin_nx));
    wgray_nx = g32[ADDRSIZE:0];
    // Full: writer is one lap ahead, i.e. top two Gray bits inverted.
    full_cmp = {~w.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                w.wq2_rptr[ADDRSIZE-2:0]};
    diff     = wbin_nx - rbin;

    wbin_d   = wbin_nx;
    wptr_d   = wgray_nx;
    wfull_d  = (wgray_nx == full_cmp);
    wafull_d = (diff >= AF);
    wovf_d   = wovf_q | (w.winc & wfull_q);
`ifdef FIFO_WLEVEL_EN
    wlevel_d = diff;
`endif

    if (w.clear) begin
      wbin_d   = '0;
      wptr_d   = '0;
      wfull_d  = 1'b0;
      wafull_d = 1'b0;
      wovf_d   = 1'b0;
`ifdef FIFO_WLEVEL_EN
      wlevel_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
`ifdef FIFO_WLEVEL_EN
      wlevel_q <= '0;
`endif
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
`ifdef FIFO_WLEVEL_EN
      wlevel_q <= wlevel_d;
`endif
    end
  end

  assign w.waddr        = wbin_q[ADDRSIZE-1:0];
  assign w.wptr         = wptr_q;
  assign w.wfull        = wfull_q;
  assign w.walmost_full = wafull_q;
  assign w.wovf         = wovf_q;
`ifdef FIFO_WLEVEL_EN
  assign w.wlevel       = wlevel_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full, ADDRSIZE=5, AFULL_THRESH=28.
// Read pointer is driven directly as Gray code.
module tb_fifo_wptr_full;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  fifo_wptr_full_if #(.ADDRSIZE(5)) w_if ();

  fifo_wptr_full #(
    .ADDRSIZE     (5),
    .AFULL_THRESH (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .w   (w_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] gray(input logic [5:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".waddr"}, 32'(w_if.waddr), 0);
    chk({tag, ".wptr"},  32'(w_if.wptr), 0);
    chk({tag, ".wfull"}, 32'(w_if.wfull), 0);
    chk({tag, ".afull"}, 32'(w_if.walmost_full), 0);
    chk({tag, ".wovf"},  32'(w_if.wovf), 0);
  endtask

  logic [5:0] m;
  logic [5:0] prev;

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0;
    w_if.clear = 1'b0;
    w_if.winc = 1'b0;
    w_if.wq2_rptr = '0;
    #2;
    chk_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // Fill from empty: 32 writes.
    w_if.winc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("fill.waddr", 32'(w_if.waddr), 32'(i));
      tick();
      chk("fill.afull", 32'(w_if.walmost_full), 32'(i + 1 >= 28));
      chk("fill.wfull", 32'(w_if.wfull), 32'(i + 1 == 32));
    end
    chk("fill.wptr", 32'(w_if.wptr), 32'h30);
    chk("fill.wovf", 32'(w_if.wovf), 0);

    // Writes while full are blocked and flag overflow.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf.wptr", 32'(w_if.wptr), 32'h30);
      chk("ovf.wovf", 32'(w_if.wovf), 1);
      chk("ovf.wfull", 32'(w_if.wfull), 1);
    end
    w_if.winc = 1'b0;

    // One read frees a slot.
    w_if.wq2_rptr = gray(6'd1);
    tick();
    chk("rd1.wfull", 32'(w_if.wfull), 0);
    w_if.winc = 1'b1;
    tick();
    w_if.winc = 1'b0;
    chk("rd1.waddr", 32'(w_if.waddr), 1);
    chk("rd1.wptr", 32'(w_if.wptr), 32'h31);
    chk("rd1.wfull", 32'(w_if.wfull), 1);
    chk("rd1.wovf", 32'(w_if.wovf), 1);

    // Flush.
    w_if.clear = 1'b1;
    tick();
    w_if.clear = 1'b0;
    w_if.wq2_rptr = '0;
    chk_zero("clr");

    // Pointer wrap with reader tracking the writer.
    m = '0;
    w_if.winc = 1'b1;
    for (int k = 0; k < 70; k++) begin
      w_if.wq2_rptr = gray(m);
      prev = w_if.wptr;
      tick();
      m = m + 6'd1;
      chk("wrap.wptr", 32'(w_if.wptr), 32'(gray(m)));
      chk("wrap.1bit", $countones(prev ^ w_if.wptr), 1);
      chk("wrap.wfull", 32'(w_if.wfull), 0);
      if (m == 6'd0) begin
        chk("wrap.prev", 32'(prev), 32'h20);
        chk("wrap.zero", 32'(w_if.wptr), 0);
      end
    end
    w_if.winc = 1'b0;

    // clear and winc together at level 10.
    w_if.clear = 1'b1;
    tick();
    w_if.clear = 1'b0;
    w_if.wq2_rptr = '0;
    w_if.winc = 1'b1;
    repeat (10) tick();
    chk("lvl10.waddr", 32'(w_if.waddr), 10);
    w_if.clear = 1'b1;
    tick();
    w_if.clear = 1'b0;
    w_if.winc = 1'b0;
    chk_zero("clrwr");
    w_if.winc = 1'b1;
    tick();
    w_if.winc = 1'b0;
    chk("clrwr.next", 32'(w_if.waddr), 1);

    // Async reset in the middle of a burst.
    w_if.winc = 1'b1;
    repeat (3) tick();
    chk("burst.waddr", 32'(w_if.waddr), 4);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async");
    tick();
    chk("rsthold.waddr", 32'(w_if.waddr), 0);
    rst = 1'b1;
    chk("post.waddr0", 32'(w_if.waddr), 0);
    tick();
    chk("post.waddr1", 32'(w_if.waddr), 1);
    w_if.winc = 1'b0;

`ifdef FIFO_WLEVEL_EN
    w_if.clear = 1'b1;
    tick();
    w_if.clear = 1'b0;
    w_if.wq2_rptr = '0;
    w_if.winc = 1'b1;
    repeat (7) tick();
    w_if.winc = 1'b0;
    chk("lvl.7", 32'(w_if.wlevel), 7);
    w_if.wq2_rptr = gray(6'd3);
    tick();
    chk("lvl.4", 32'(w_if.wlevel), 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
